// File: rtl/switch_pkg.sv
// rtl/switch_pkg.sv - shared defaults, decoder wiring indices and per-bit state type for the switch debouncer
package switch_pkg;

    localparam int SW_WIDTH_DEF      = 6;
    localparam int SYNC_STAGES_DEF   = 2;
    localparam int STABLE_CYCLES_DEF = 1000000;

    // Slices of sw_clean feeding the 3-to-8 LED decoder
    localparam int SEL_LSB = 0;
    localparam int SEL_MSB = 2;
    localparam int EN_LSB  = 3;
    localparam int EN_MSB  = 5;

    typedef enum logic {
        BIT_STABLE  = 1'b0,
        BIT_PENDING = 1'b1
    } bit_state_e;

endpackage

// File: rtl/debounce_bit.sv
// rtl/debounce_bit.sv - one switch bit: synchroniser chain, stability counter, clean level and edge strobes
module debounce_bit
    import switch_pkg::*;
#(
    parameter int SYNC_STAGES   = SYNC_STAGES_DEF,
    parameter int STABLE_CYCLES = STABLE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sw_raw,
    output logic sw_clean,
    output logic sw_rise,
    output logic sw_fall
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       cnt_d;
    logic                   clean_d;
    logic                   rise_d;
    logic                   fall_d;
    bit_state_e             state;

    assign sync = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sw_raw};
        end
    end

    // Counter only runs while the synchronised level disagrees with the accepted one
    always_comb begin
        state   = BIT_STABLE;
        cnt_d   = '0;
        clean_d = sw_clean;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (sync != sw_clean) begin
            state = BIT_PENDING;
        end
        if (state == BIT_PENDING) begin
            if (cnt == CNT_LAST) begin
                clean_d = sync;
                rise_d  = sync;
                fall_d  = ~sync;
            end else begin
                cnt_d = cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            sw_clean <= 1'b0;
            sw_rise  <= 1'b0;
            sw_fall  <= 1'b0;
        end else begin
            cnt      <= cnt_d;
            sw_clean <= clean_d;
            sw_rise  <= rise_d;
            sw_fall  <= fall_d;
        end
    end

endmodule

// File: rtl/switch_debouncer.sv
// rtl/switch_debouncer.sv - WIDTH independent debounced switch bits with a combined change strobe
module switch_debouncer
    import switch_pkg::*;
#(
    parameter int WIDTH         = SW_WIDTH_DEF,
    parameter int SYNC_STAGES   = SYNC_STAGES_DEF,
    parameter int STABLE_CYCLES = STABLE_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_clean,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic             changed
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        debounce_bit #(
            .SYNC_STAGES  (SYNC_STAGES),
            .STABLE_CYCLES(STABLE_CYCLES)
        ) u_bit (
            .clk     (clk),
            .rst_n   (rst_n),
            .sw_raw  (sw_raw[i]),
            .sw_clean(sw_clean[i]),
            .sw_rise (sw_rise[i]),
            .sw_fall (sw_fall[i])
        );
    end

    // Pure OR of registered strobes, so it pulses in the same cycle as them
    assign changed = |(sw_rise | sw_fall);

endmodule

// File: tb/tb_switch_debouncer.sv
// tb/tb_switch_debouncer.sv - scoreboard bench for switch_debouncer with SYNC_STAGES=2, STABLE_CYCLES=4
module tb_switch_debouncer;
    import switch_pkg::*;

    localparam int W   = SW_WIDTH_DEF;
    localparam int LAT = 6;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] sw_raw;
    logic [W-1:0] sw_clean;
    logic [W-1:0] sw_rise;
    logic [W-1:0] sw_fall;
    logic         changed;

    switch_debouncer #(
        .WIDTH        (W),
        .SYNC_STAGES  (2),
        .STABLE_CYCLES(4)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .sw_raw  (sw_raw),
        .sw_clean(sw_clean),
        .sw_rise (sw_rise),
        .sw_fall (sw_fall),
        .changed (changed)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int           at;
        logic [W-1:0] clean;
        logic [W-1:0] rise;
        logic [W-1:0] fall;
    } exp_t;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_at(input int at, input logic [W-1:0] clean,
                             input logic [W-1:0] rise, input logic [W-1:0] fall);
        exp_t e;
        e.at    = at;
        e.clean = clean;
        e.rise  = rise;
        e.fall  = fall;
        sb.push_back(e);
    endtask

    task automatic set_raw(input logic [W-1:0] v, output int k);
        @(negedge clk);
        sw_raw = v;
        k      = cyc;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: any strobe activity must match the head of the scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1 && (changed !== 1'b0 || sw_rise !== '0 || sw_fall !== '0)) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_strobe: cycle %0d rise=%b fall=%b changed=%b, required none",
                         cyc, sw_rise, sw_fall, changed);
            end else begin
                e = sb.pop_front();
                check("strobe_cycle", cyc, e.at);
                check("strobe_clean", sw_clean, e.clean);
                check("strobe_rise", sw_rise, e.rise);
                check("strobe_fall", sw_fall, e.fall);
                check("strobe_changed", changed, 1);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d required < 20000", cyc);
        $fatal(1);
    end

    initial begin
        int k, k2, r;
        rst_n  = 1'b0;
        sw_raw = '0;
        idle(3);
        #1;
        check("reset_clean", sw_clean, 0);
        check("reset_rise", sw_rise, 0);
        check("reset_fall", sw_fall, 0);
        check("reset_changed", changed, 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(20);
        check("quiet_clean", sw_clean, 0);

        // Single bit rise
        set_raw(6'b000001, k);
        expect_at(k + LAT, 6'b000001, 6'b000001, 6'b000000);
        idle(10);

        // 3-cycle glitch is filtered
        set_raw(6'b000011, k);
        idle(2);
        set_raw(6'b000001, k2);
        idle(10);
        check("glitch_clean", sw_clean, 6'b000001);

        // 4-cycle pulse is the shortest accepted
        set_raw(6'b000011, k);
        idle(3);
        set_raw(6'b000001, k2);
        expect_at(k + LAT, 6'b000011, 6'b000010, 6'b000000);
        expect_at(k2 + LAT, 6'b000001, 6'b000000, 6'b000010);
        idle(12);

        // Bounce 1,0,1,0,1 then hold
        set_raw(6'b000101, k);
        set_raw(6'b000001, k);
        set_raw(6'b000101, k);
        set_raw(6'b000001, k);
        set_raw(6'b000101, k);
        expect_at(k + LAT, 6'b000101, 6'b000100, 6'b000000);
        idle(12);

        // Clear, then simultaneous multi-bit rise and fall
        set_raw(6'b000000, k);
        expect_at(k + LAT, 6'b000000, 6'b000000, 6'b000101);
        idle(10);
        set_raw(6'b101010, k);
        expect_at(k + LAT, 6'b101010, 6'b101010, 6'b000000);
        idle(10);
        set_raw(6'b000000, k);
        expect_at(k + LAT, 6'b000000, 6'b000000, 6'b101010);
        idle(10);

        // Reset mid-count
        set_raw(6'b001000, k);
        idle(4);
        rst_n = 1'b0;
        #1;
        check("midreset_clean", sw_clean, 0);
        check("midreset_changed", changed, 0);
        idle(2);
        rst_n = 1'b1;
        r     = cyc;
        expect_at(r + LAT, 6'b001000, 6'b001000, 6'b000000);
        idle(12);
        check("postreset_clean", sw_clean, 6'b001000);

        check("missed_strobes", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
